// File: rtl/ram_pkg.sv
// Shared constants, state type and parameter checks for the pipelined simple dual-port RAM.
package ram_pkg;

    localparam int RF = 0;
    localparam int WF = 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } ram_state_t;

    function automatic int lanes_of(input int width, input int lane_w);
        return width / lane_w;
    endfunction

    function automatic bit params_ok(input int width, input int depth, input int rd_lat,
                                     input int lane_w, input int write_first);
        return (lane_w > 0) && (width % lane_w == 0) && (rd_lat >= 1) && (depth >= 2) &&
               ((write_first == RF) || (write_first == WF));
    endfunction

endpackage

// File: rtl/ram_delay_pipe.sv
// N-stage data+valid delay line; data only advances alongside its valid bit.
module ram_delay_pipe #(
    parameter int W = 8,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    if (N == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = clk ^ rst;
        assign out_valid   = in_valid;
        assign out_data    = in_data;
    end else begin : g_pipe
        logic [W-1:0] data_q  [N];
        logic         valid_q [N];

        // holding data on idle stages keeps the last delivered word stable at the output
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < N; k++) begin
                    valid_q[k] <= 1'b0;
                    data_q[k]  <= '0;
                end
            end else begin
                valid_q[0] <= in_valid;
                if (in_valid) data_q[0] <= in_data;
                for (int k = 1; k < N; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) data_q[k] <= data_q[k-1];
                end
            end
        end

        assign out_valid = valid_q[N-1];
        assign out_data  = data_q[N-1];
    end

endmodule

// File: rtl/pipe_sdp_ram.sv
// Simple dual-port RAM with lane write enables, registered read pipeline,
// defined collision policy and an optional post-reset zeroing sweep.
module pipe_sdp_ram
    import ram_pkg::*;
#(
    parameter int WIDTH        = 272,
    parameter int DEPTH        = 141,
    parameter int AW           = $clog2(DEPTH),
    parameter int RD_LAT       = 3,
    parameter int LANE_W       = 272,
    parameter int WRITE_FIRST  = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH/LANE_W-1:0]   wr_lane,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      busy
);

    localparam int              LANES     = lanes_of(WIDTH, LANE_W);
    localparam logic [AW:0]     DEPTH_X   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    if (!params_ok(WIDTH, DEPTH, RD_LAT, LANE_W, WRITE_FIRST)) begin : g_bad_params
        $error("pipe_sdp_ram: illegal parameter combination");
    end

    ram_state_t       state;
    logic [AW-1:0]    clr_addr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             run;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic             rd_fire;
    logic             collide;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] merged_word;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_comb begin
        run         = (state == ST_RUN) && !rst;
        wr_in_range = {1'b0, wr_addr} < DEPTH_X;
        rd_in_range = {1'b0, rd_addr} < DEPTH_X;
        wr_fire     = run && wr_en && wr_in_range;
        rd_fire     = run && rd_en;
        collide     = wr_fire && rd_in_range && (wr_addr == rd_addr);
        wr_mask     = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_mask[i*LANE_W +: LANE_W] = {LANE_W{wr_lane[i]}};
        end
        rd_word     = rd_in_range ? mem[rd_addr] : '0;
        merged_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
    end

    // busy mirrors the CLEAR state but is registered so it has no path from rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            busy     <= (CLEAR_ON_RST != 0);
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                state <= ST_RUN;
                busy  <= 1'b0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_CLEAR) && !rst) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    // the array-read stage is where the collision policy is resolved
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) s1_data <= ((WRITE_FIRST == WF) && collide) ? merged_word : rd_word;
        end
    end

    ram_delay_pipe #(
        .W (WIDTH),
        .N (RD_LAT - 1)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_pipe_sdp_ram.sv
// Scoreboard bench: two RAM configurations (read-first/latency 3, write-first/latency 1) share one stimulus stream.
module tb_pipe_sdp_ram;

    localparam int WIDTH  = 272;
    localparam int DEPTH  = 141;
    localparam int AW     = 8;
    localparam int LANE_W = 68;
    localparam int LANES  = 4;
    localparam int LAT_A  = 3;
    localparam int LAT_B  = 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [LANES-1:0] wr_lane;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data_a, rd_data_b;
    logic             rd_valid_a, rd_valid_b;
    logic             busy_a, busy_b;

    exp_t             q [2][$];
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] hold [2];
    int               cyc = 0;
    int               busy_from = 0;
    int               run_from = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    bit               mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pipe_sdp_ram #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(LAT_A), .LANE_W(LANE_W),
        .WRITE_FIRST(0), .CLEAR_ON_RST(1)
    ) u_dut_rf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .busy(busy_a)
    );

    pipe_sdp_ram #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(LAT_B), .LANE_W(LANE_W),
        .WRITE_FIRST(1), .CLEAR_ON_RST(1)
    ) u_dut_wf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .busy(busy_b)
    );

    function automatic logic [WIDTH-1:0] lane_mask(input logic [LANES-1:0] lane);
        logic [WIDTH-1:0] m = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane[i]) m = m | (({WIDTH{1'b1}} >> (WIDTH - LANE_W)) << (i * LANE_W));
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        return t[WIDTH-1:0];
    endfunction

    task automatic check_output(input string name, input int port,
                                input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s port%0d cycle %0d: got %h required %h", name, port, cyc, act, req);
        end
    endtask

    // Drives one cycle of inputs and updates the reference model for what the RAM should do with them.
    task automatic apply_stimulus(input logic r, input logic we, input logic [LANES-1:0] lane,
                                  input int waddr, input logic [WIDTH-1:0] wdata,
                                  input logic re, input int raddr);
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] old_w;
        exp_t             e;
        @(posedge clk);
        #1;
        rst = r; wr_en = we; wr_lane = lane; wr_addr = AW'(waddr); wr_data = wdata;
        rd_en = re; rd_addr = AW'(raddr);
        if (r) begin
            for (int p = 0; p < 2; p++) begin
                while (q[p].size() > 0 && q[p][q[p].size()-1].due > cyc) void'(q[p].pop_back());
            end
            if (!(cyc >= busy_from && cyc < run_from)) busy_from = cyc + 1;
            run_from = cyc + 1 + DEPTH;
            for (int a = 0; a < DEPTH; a++) model[a] = '0;
        end else if (cyc >= run_from) begin
            mask  = lane_mask(lane);
            old_w = (raddr < DEPTH) ? model[raddr] : '0;
            if (re) begin
                e.data = old_w;
                e.due  = cyc + LAT_A;
                q[0].push_back(e);
                e.data = (we && waddr == raddr && waddr < DEPTH) ? ((old_w & ~mask) | (wdata & mask)) : old_w;
                e.due  = cyc + LAT_B;
                q[1].push_back(e);
            end
            if (we && waddr < DEPTH) model[waddr] = (model[waddr] & ~mask) | (wdata & mask);
        end
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b0, 0);
    endtask

    task automatic wait_run();
        while (cyc + 1 < run_from) idle();
    endtask

    // Monitor: compares busy every cycle, pops one expected word per rd_valid, checks hold when idle.
    always @(negedge clk) begin
        logic             v [2];
        logic             b [2];
        logic [WIDTH-1:0] d [2];
        logic             busy_exp;
        exp_t             e;
        if (mon_en) begin
            v[0] = rd_valid_a; v[1] = rd_valid_b;
            b[0] = busy_a;     b[1] = busy_b;
            d[0] = rd_data_a;  d[1] = rd_data_b;
            busy_exp = (cyc >= busy_from) && (cyc < run_from);
            for (int p = 0; p < 2; p++) begin
                check_output("busy", p, WIDTH'(b[p]), WIDTH'(busy_exp));
                if (v[p]) begin
                    if (q[p].size() == 0) begin
                        check_output("unexpected_valid", p, WIDTH'(v[p]), WIDTH'(1'b0));
                    end else begin
                        e = q[p].pop_front();
                        check_output("rd_data", p, d[p], e.data);
                        check_output("valid_cycle", p, WIDTH'(cyc), WIDTH'(e.due));
                        hold[p] = e.data;
                    end
                end else begin
                    check_output("rd_data_hold", p, d[p], hold[p]);
                    if (q[p].size() > 0 && q[p][0].due <= cyc) begin
                        void'(q[p].pop_front());
                        check_output("missing_valid", p, WIDTH'(v[p]), WIDTH'(1'b1));
                    end
                end
                if (rst) hold[p] = '0;
            end
        end
    end

    initial begin
        int wa;
        int ra;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_lane = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        hold[0] = '0; hold[1] = '0;

        apply_stimulus(1'b1, 1'b0, 4'h0, 0, '0, 1'b0, 0);
        apply_stimulus(1'b1, 1'b0, 4'h0, 0, '0, 1'b0, 0);
        mon_en = 1'b1;

        // traffic during the clear sweep must be ignored
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b0, 1'b1, 4'hF, $urandom_range(0, 140), rand_word(), 1'b1, $urandom_range(0, 140));
        wait_run();

        for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, a);

        for (int k = 0; k < DEPTH; k++)
            apply_stimulus(1'b0, 1'b1, 4'hF, k, WIDTH'(k * 32'h0001_0001), 1'b0, 0);
        for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, a);
        repeat (5) idle();

        // lane masking
        apply_stimulus(1'b0, 1'b1, 4'hF, 5, {WIDTH{1'b1}}, 1'b0, 0);
        apply_stimulus(1'b0, 1'b1, 4'b0101, 5, '0, 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 5);

        // same-address collision, full and partial lanes
        apply_stimulus(1'b0, 1'b1, 4'hF, 7, WIDTH'(16'hAAAA), 1'b0, 0);
        apply_stimulus(1'b0, 1'b1, 4'hF, 7, WIDTH'(16'h5555), 1'b1, 7);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 7);
        apply_stimulus(1'b0, 1'b1, 4'b0010, 7, rand_word(), 1'b1, 7);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 7);

        // address boundaries
        apply_stimulus(1'b0, 1'b1, 4'hF, 140, rand_word(), 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 140);
        apply_stimulus(1'b0, 1'b1, 4'hF, 141, rand_word(), 1'b0, 0);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 141);
        apply_stimulus(1'b0, 1'b1, 4'hF, 255, rand_word(), 1'b1, 255);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 140);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 0);
        repeat (5) idle();

        for (int i = 0; i < 400; i++) begin
            wa = $urandom_range(0, 150);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 150);
            apply_stimulus(1'b0, 1'($urandom), 4'($urandom), wa, rand_word(), 1'($urandom), ra);
        end

        // reset with reads in flight, then a second reset part-way through the sweep
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, 2);
        apply_stimulus(1'b1, 1'b0, 4'h0, 0, '0, 1'b1, 3);
        repeat (70) idle();
        apply_stimulus(1'b1, 1'b0, 4'h0, 0, '0, 1'b0, 0);
        wait_run();
        for (int a = 0; a < 10; a++) apply_stimulus(1'b0, 1'b0, 4'h0, 0, '0, 1'b1, a * 14);

        for (int i = 0; i < 100; i++) begin
            wa = $urandom_range(0, 145);
            ra = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 145);
            apply_stimulus(1'b0, 1'($urandom), 4'($urandom), wa, rand_word(), 1'($urandom), ra);
        end
        repeat (8) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
